// File: rtl/ac_motor_pwm_gen.sv
// Center-aligned triangular PWM carrier for one motor phase leg, with valley-loaded
// period/duty shadows. Optional minimum-pulse duty conditioning: AC_MOTOR_PWM_MIN_PULSE_EN.
module ac_motor_pwm_gen #(
    parameter int unsigned W         = 11,
    parameter int unsigned MIN_PULSE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic [W-1:0] period,
    input  logic [W-1:0] duty,
    output logic         s_out,
    output logic         sync,
    output logic [W-1:0] cnt
);

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_e;

    dir_e         dir_q, dir_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] period_sh_q, period_sh_d;
    logic [W-1:0] duty_sh_q, duty_sh_d;
    logic         s_out_q, s_out_d;
    logic         sync_q, sync_d;
    logic [W-1:0] duty_ld;
    logic         at_valley;
    logic         zero_period;

    assign at_valley   = (cnt_q == '0);
    assign zero_period = (period_sh_q == '0);

`ifdef AC_MOTOR_PWM_MIN_PULSE_EN
    // Drop or fill pulses too narrow to survive the dead-time stage.
    localparam int unsigned XW = W + 2;

    logic [XW-1:0] hi_width;
    logic [XW-1:0] lo_width;
    logic [XW-1:0] min_pulse_x;
    logic          duty_mid;

    always_comb begin
        min_pulse_x = XW'(MIN_PULSE);
        duty_mid    = (duty != '0) && (duty < period);
        hi_width    = (XW'(duty) << 1) - XW'(1);
        lo_width    = ((XW'(period) - XW'(duty)) << 1) + XW'(1);
        duty_ld     = duty;
        if (duty_mid) begin
            if (hi_width < min_pulse_x) begin
                duty_ld = '0;
            end else if (lo_width < min_pulse_x) begin
                duty_ld = period;
            end
        end
    end
`else
    logic unused_min_pulse;

    assign unused_min_pulse = (MIN_PULSE != 0);
    assign duty_ld          = duty;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            dir_q       <= DIR_UP;
            period_sh_q <= '0;
            duty_sh_q   <= '0;
            s_out_q     <= 1'b0;
            sync_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            period_sh_q <= period_sh_d;
            duty_sh_q   <= duty_sh_d;
            s_out_q     <= s_out_d;
            sync_q      <= sync_d;
        end
    end

    // Next-state: shadow load at the valley, triangular count, compare against the old duty
    always_comb begin
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        period_sh_d = period_sh_q;
        duty_sh_d   = duty_sh_q;
        s_out_d     = 1'b0;
        sync_d      = 1'b0;

        if (at_valley) begin
            period_sh_d = period;
            duty_sh_d   = duty_ld;
        end

        if (!enable || zero_period) begin
            cnt_d = '0;
            dir_d = DIR_UP;
        end else begin
            sync_d = at_valley;

            if (duty_sh_q >= period_sh_q) begin
                s_out_d = 1'b1;
            end else if (duty_sh_q == '0) begin
                s_out_d = 1'b0;
            end else begin
                s_out_d = (cnt_q < duty_sh_q);
            end

            case (dir_q)
                DIR_UP: begin
                    if (cnt_q == period_sh_q) begin
                        // A period of one has no down leg: 0,1,0,1...
                        cnt_d = cnt_q - W'(1);
                        dir_d = (cnt_q == W'(1)) ? DIR_UP : DIR_DN;
                    end else begin
                        cnt_d = cnt_q + W'(1);
                    end
                end
                DIR_DN: begin
                    cnt_d = cnt_q - W'(1);
                    if (cnt_q == W'(1)) begin
                        dir_d = DIR_UP;
                    end
                end
            endcase
        end
    end

    assign cnt   = cnt_q;
    assign s_out = s_out_q;
    assign sync  = sync_q;

endmodule

// File: tb/tb_ac_motor_pwm_gen.sv
// Bench for ac_motor_pwm_gen: directed carrier checks plus random traffic against a
// phase-index carrier model. Define AC_MOTOR_PWM_MIN_PULSE_EN to cover the duty conditioning.
module tb_ac_motor_pwm_gen;

    localparam int unsigned W    = 11;
    localparam int unsigned MINP = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic [W-1:0] period;
    logic [W-1:0] duty;
    logic         s_out;
    logic         sync;
    logic [W-1:0] cnt;

    int total = 0;
    int bad   = 0;

    // Model state: position k within the 2P-long carrier, plus shadows and outputs.
    int m_k, m_cnt, m_ps, m_ds;
    bit m_s, m_sync;

    ac_motor_pwm_gen #(.W(W), .MIN_PULSE(MINP)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .period (period),
        .duty   (duty),
        .s_out  (s_out),
        .sync   (sync),
        .cnt    (cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int cond_duty(input int d, input int p);
`ifdef AC_MOTOR_PWM_MIN_PULSE_EN
        if (d > 0 && d < p) begin
            if (2 * d - 1 < int'(MINP)) return 0;
            if (2 * (p - d) + 1 < int'(MINP)) return p;
        end
`endif
        return d;
    endfunction

    task automatic model_reset();
        m_k = 0; m_cnt = 0; m_ps = 0; m_ds = 0; m_s = 1'b0; m_sync = 1'b0;
    endtask

    task automatic model_step();
        int ps;
        int ds;
        int c;
        bit run;
        ps  = m_ps;
        ds  = m_ds;
        c   = m_cnt;
        run = enable && (ps != 0);
        if (!rst_n) begin
            model_reset();
        end else begin
            m_s    = run && ((ds >= ps) ? 1'b1 : ((ds == 0) ? 1'b0 : (c < ds)));
            m_sync = run && (c == 0);
            if (c == 0) begin
                m_ps = int'(period);
                m_ds = cond_duty(int'(duty), int'(period));
            end
            if (!run) begin
                m_k   = 0;
                m_cnt = 0;
            end else begin
                m_k   = (m_k + 1) % (2 * ps);
                m_cnt = (m_k <= ps) ? m_k : 2 * ps - m_k;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("cnt", 32'(cnt), m_cnt);
        check("s_out", 32'(s_out), 32'(m_s));
        check("sync", 32'(sync), 32'(m_sync));
    endtask

    // Count s_out highs over one P=10 carrier starting at a sync pulse.
    task automatic window(input string tag, input int exp_hi, input int chg_at, input int chg_duty);
        int n;
        int hi;
        n  = 0;
        hi = 0;
        while (sync !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_sync_seen"}, 32'(sync), 1);
        for (int i = 0; i < 20; i++) begin
            if (i == chg_at) duty = W'(chg_duty);
            hi += int'(s_out);
            tick();
        end
        check({tag, "_high"}, hi, exp_hi);
        check({tag, "_next_sync"}, 32'(sync), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int n;
        int acc;
        rst_n  = 1'b1;
        enable = 1'b0;
        period = '0;
        duty   = '0;
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_cnt", 32'(cnt), 0);
        check("rst_s_out", 32'(s_out), 0);
        check("rst_sync", 32'(sync), 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Basic carrier P=10 D=3
        period = W'(10);
        duty   = W'(3);
        enable = 1'b1;
        window("p10_d3", 5, -1, 0);

        // Duty change mid-carrier, effective next carrier only
        window("d3_to_7_cur", 5, 4, 7);
        window("d7_next", 13, -1, 0);

        // Duty extremes
        duty = W'(0);
        repeat (25) tick();
        window("d0", 0, -1, 0);
        duty = W'(10);
        repeat (25) tick();
        window("d_eq_p", 20, -1, 0);
        duty = W'(2047);
        repeat (25) tick();
        window("d_max", 20, -1, 0);

        // Enable drop at cnt==6, then re-enable
        duty = W'(3);
        n = 0;
        while (cnt !== W'(6) && n < 40) begin
            tick();
            n++;
        end
        check("reach_cnt6", 32'(cnt), 6);
        enable = 1'b0;
        tick();
        check("dis_cnt", 32'(cnt), 0);
        check("dis_s_out", 32'(s_out), 0);
        check("dis_sync", 32'(sync), 0);
        repeat (3) tick();
        enable = 1'b1;
        tick();
        check("reen_sync", 32'(sync), 1);
        check("reen_cnt", 32'(cnt), 1);
        window("reen_d3", 5, -1, 0);

        // Asynchronous reset between edges
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_cnt", 32'(cnt), 0);
        check("arst_s_out", 32'(s_out), 0);
        check("arst_sync", 32'(sync), 0);
        tick();
        period = '0;
        duty   = W'(5);
        enable = 1'b1;
        rst_n  = 1'b1;

        // Zero period holds the counter and suppresses sync
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            acc += int'(cnt) + int'(sync) + int'(s_out);
        end
        check("p0_idle", acc, 0);
        period = W'(10);
        tick();
        check("p0_accept_cnt", 32'(cnt), 0);
        tick();
        check("p0_first_sync", 32'(sync), 1);
        window("p10_d5", 9, -1, 0);

`ifdef AC_MOTOR_PWM_MIN_PULSE_EN
        duty = W'(1);
        repeat (25) tick();
        window("mp_d1", 0, -1, 0);
        duty = W'(9);
        repeat (25) tick();
        window("mp_d9", 20, -1, 0);
        duty = W'(3);
        repeat (25) tick();
        window("mp_d3", 5, -1, 0);
`else
        duty = W'(1);
        repeat (25) tick();
        window("nomp_d1", 1, -1, 0);
`endif

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) period = W'($urandom_range(0, 24));
            if ($urandom_range(0, 14) == 0) begin
                if ($urandom_range(0, 7) == 0) duty = W'(2047);
                else duty = W'($urandom_range(0, 30));
            end
            if ($urandom_range(0, 99) == 0) enable = ~enable;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
